// File: rtl/mrd_pkg.sv
// -----------------------------------------------------------------------------
// mrd_pkg
// Shared definitions for the mixed-radix (2/3/4/5) DFT read and write
// sequencers: bank count, largest radix, the radix factor type, the sequencer
// FSM state encoding and a factor legality helper.
// -----------------------------------------------------------------------------
package mrd_pkg;

   localparam int NBANK     = 5;
   localparam int MAX_RADIX = 5;

   typedef logic [2:0] mrd_factor_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } mrd_seq_state_t;

   // Only radix 2..5 butterflies exist in the datapath.
   function automatic logic factor_legal(input mrd_factor_t f);
      return (f >= 3'd2) && (f <= 3'(MAX_RADIX));
   endfunction

endpackage

// File: rtl/mrd_rdx2345_if.sv
// -----------------------------------------------------------------------------
// mrd_rdx2345_if
// Read-beat stream from the stage sequencer (master) through the memory /
// butterfly switch into the butterfly (slave).
//   rd_valid        beat valid
//   rd_factor       radix of the beat
//   rd_bank_index   per-lane bank index
//   rd_bank_addr    per-lane bank address
//   rd_twdl_numrtr  twiddle numerator (butterfly index k)
//   rd_twdl_demontr twiddle denominator (factor * nbfly)
// -----------------------------------------------------------------------------
interface mrd_rdx2345_if
   import mrd_pkg::*;
#(
   parameter int NB_W   = 12,
   parameter int ADDR_W = 12
) ();

   logic                              rd_valid;
   mrd_factor_t                       rd_factor;
   logic [NBANK-1:0][2:0]             rd_bank_index;
   logic [NBANK-1:0][ADDR_W-1:0]      rd_bank_addr;
   logic [NB_W-1:0]                   rd_twdl_numrtr;
   logic [NB_W+2:0]                   rd_twdl_demontr;

   modport master (
      output rd_valid, rd_factor, rd_bank_index, rd_bank_addr,
             rd_twdl_numrtr, rd_twdl_demontr
   );

   modport slave (
      input  rd_valid, rd_factor, rd_bank_index, rd_bank_addr,
             rd_twdl_numrtr, rd_twdl_demontr
   );

endinterface

// File: rtl/mrd_mod5_cnt.sv
// -----------------------------------------------------------------------------
// mrd_mod5_cnt
// 3-bit skew counter that wraps 4 -> 0, plus per-lane (lane + s) mod 5 offsets
// computed by a single conditional subtract instead of a divider.
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear (wins over en)
//   en           advance by one
//   s            current skew
//   lane_bank    (i + s) mod 5 for each lane i
// -----------------------------------------------------------------------------
module mrd_mod5_cnt
   import mrd_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   output logic [2:0]            s,
   output logic [NBANK-1:0][2:0] lane_bank
);

   logic [2:0] s_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_reg <= 3'd0;
      end else if (clr) begin
         s_reg <= 3'd0;
      end else if (en) begin
         s_reg <= (s_reg == 3'd4) ? 3'd0 : s_reg + 3'd1;
      end
   end

   assign s = s_reg;

   // lane + s is at most 8, so one subtract of 5 is enough to fold it back.
   for (genvar gi = 0; gi < NBANK; gi++) begin : g_lane
      logic [3:0] sum;
      logic [3:0] wrapped;
      assign sum           = 4'(gi) + {1'b0, s_reg};
      assign wrapped       = sum - 4'd5;
      assign lane_bank[gi] = (sum >= 4'd5) ? wrapped[2:0] : sum[2:0];
   end

endmodule

// File: rtl/mrd_stage_seq.sv
// -----------------------------------------------------------------------------
// mrd_stage_seq
// Read-side stage sequencer for the mixed-radix DFT engine. Walks the
// programmed stage list, issues one butterfly read beat per cycle and drives
// the ping-pong select of the memory/butterfly switch.
//   clk, rst_n       clock, asynchronous active-low reset
//   start            launch pulse (ignored while busy)
//   cfg_num_stages   stage count, sampled at start
//   cfg_factor       per-stage radix (3 bits each)
//   cfg_nbfly        per-stage butterfly count (NB_W bits each)
//   hold             stall: no beat, counters frozen
//   wr_last          write path finished the current stage
//   rd               read-beat stream (master side)
//   sw               ping-pong select
//   stage_idx        current stage
//   busy, done, err  status (err is sticky until the next accepted start)
// -----------------------------------------------------------------------------
module mrd_stage_seq
   import mrd_pkg::*;
#(
   parameter int MAX_STAGES = 8,
   parameter int NB_W       = 12,
   parameter int ADDR_W     = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [3:0]                 cfg_num_stages,
   input  logic [MAX_STAGES*3-1:0]    cfg_factor,
   input  logic [MAX_STAGES*NB_W-1:0] cfg_nbfly,
   input  logic                       hold,
   input  logic                       wr_last,
   mrd_rdx2345_if.master              rd,
   output logic                       sw,
   output logic [2:0]                 stage_idx,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   mrd_seq_state_t state_reg, state_next;

   logic [MAX_STAGES*3-1:0]    tbl_f_reg;
   logic [MAX_STAGES*NB_W-1:0] tbl_nb_reg;
   logic [3:0]                 num_stages_reg;
   mrd_factor_t                f_reg;
   logic [NB_W-1:0]            nb_reg;
   logic [NB_W-1:0]            k_reg;
   logic                       sw_reg, busy_reg, done_reg, err_reg;
   logic [2:0]                 stage_reg;

   logic                             rd_valid_reg;
   mrd_factor_t                      rd_factor_reg;
   logic [NBANK-1:0][2:0]            rd_bank_index_reg, bank_index_next;
   logic [NBANK-1:0][ADDR_W-1:0]     rd_bank_addr_reg, bank_addr_next;
   logic [NB_W-1:0]                  rd_numrtr_reg;
   logic [NB_W+2:0]                  rd_demontr_reg;

   mrd_factor_t           cur_f;
   logic [NB_W-1:0]       cur_nb;
   logic                  last_stage, last_beat, issue, stage_adv, cnt_clr;
   logic                  load_cfg;
   logic [2:0]            s_cur;
   logic [NBANK-1:0][2:0] lane_bank;

   // In LOAD the stage parameters come straight from the latched table so the
   // first beat can leave in the same cycle; afterwards the registered copy.
   assign cur_f  = (state_reg == ST_LOAD) ? tbl_f_reg[stage_reg*3 +: 3] : f_reg;
   assign cur_nb = (state_reg == ST_LOAD) ? tbl_nb_reg[stage_reg*NB_W +: NB_W] : nb_reg;

   assign last_stage = (({1'b0, stage_reg} + 4'd1) >= num_stages_reg) ||
                       (stage_reg == 3'(MAX_STAGES - 1));
   assign last_beat  = (k_reg == cur_nb - NB_W'(1));
   assign load_cfg   = (state_reg == ST_IDLE) && start;

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      stage_adv  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (!factor_legal(cur_f)) begin
               state_next = ST_DONE;
            end else if (cur_nb == '0) begin
               // Empty stage: skip it without toggling sw.
               state_next = last_stage ? ST_DONE : ST_LOAD;
               stage_adv  = !last_stage;
            end else begin
               issue      = !hold;
               state_next = (issue && last_beat) ? ST_DRAIN : ST_RUN;
            end
         end
         ST_RUN: begin
            issue = !hold;
            if (issue && last_beat) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (wr_last) begin
               state_next = last_stage ? ST_DONE : ST_LOAD;
               stage_adv  = !last_stage;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // k and s are cleared on every entry into LOAD, so LOAD always sees 0.
   assign cnt_clr = (state_next == ST_LOAD);

   mrd_mod5_cnt u_skew (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (cnt_clr),
      .en        (issue),
      .s         (s_cur),
      .lane_bank (lane_bank)
   );

   // Lanes beyond the radix carry zeros.
   for (genvar gi = 0; gi < NBANK; gi++) begin : g_lane
      assign bank_index_next[gi] = (3'(gi) < cur_f) ? lane_bank[gi] : 3'd0;
      assign bank_addr_next[gi]  = (3'(gi) < cur_f) ? ADDR_W'(k_reg) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= ST_IDLE;
         tbl_f_reg         <= '0;
         tbl_nb_reg        <= '0;
         num_stages_reg    <= '0;
         f_reg             <= '0;
         nb_reg            <= '0;
         k_reg             <= '0;
         sw_reg            <= 1'b0;
         busy_reg          <= 1'b0;
         done_reg          <= 1'b0;
         err_reg           <= 1'b0;
         stage_reg         <= '0;
         rd_valid_reg      <= 1'b0;
         rd_factor_reg     <= '0;
         rd_bank_index_reg <= '0;
         rd_bank_addr_reg  <= '0;
         rd_numrtr_reg     <= '0;
         rd_demontr_reg    <= '0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next == ST_LOAD) || (state_next == ST_RUN) ||
                      (state_next == ST_DRAIN);
         done_reg  <= (state_next == ST_DONE);

         if (load_cfg) begin
            tbl_f_reg      <= cfg_factor;
            tbl_nb_reg     <= cfg_nbfly;
            num_stages_reg <= cfg_num_stages;
            sw_reg         <= 1'b0;
            stage_reg      <= '0;
            err_reg        <= 1'b0;
         end

         if (state_reg == ST_LOAD) begin
            f_reg  <= cur_f;
            nb_reg <= cur_nb;
            if (!factor_legal(cur_f)) err_reg <= 1'b1;
         end

         if (stage_adv) stage_reg <= stage_reg + 3'd1;
         if ((state_reg == ST_DRAIN) && wr_last) sw_reg <= ~sw_reg;

         if (cnt_clr)    k_reg <= '0;
         else if (issue) k_reg <= k_reg + NB_W'(1);

         // Beat fields only move on an issued beat; they hold while stalled.
         rd_valid_reg <= issue;
         if (issue) begin
            rd_factor_reg     <= cur_f;
            rd_bank_index_reg <= bank_index_next;
            rd_bank_addr_reg  <= bank_addr_next;
            rd_numrtr_reg     <= k_reg;
            rd_demontr_reg    <= (NB_W+3)'(cur_f) * (NB_W+3)'(cur_nb);
         end
      end
   end

   assign rd.rd_valid        = rd_valid_reg;
   assign rd.rd_factor       = rd_factor_reg;
   assign rd.rd_bank_index   = rd_bank_index_reg;
   assign rd.rd_bank_addr    = rd_bank_addr_reg;
   assign rd.rd_twdl_numrtr  = rd_numrtr_reg;
   assign rd.rd_twdl_demontr = rd_demontr_reg;

   assign sw        = sw_reg;
   assign stage_idx = stage_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_mrd_stage_seq.sv
// -----------------------------------------------------------------------------
// tb_mrd_stage_seq
// Directed bench for mrd_stage_seq. Cycle 0 is the cycle in which start is
// high; outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mrd_stage_seq;
   import mrd_pkg::*;

   localparam int MAX_STAGES = 8;
   localparam int NB_W       = 12;
   localparam int ADDR_W     = 12;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic                       start = 1'b0;
   logic [3:0]                 cfg_num_stages = '0;
   logic [MAX_STAGES*3-1:0]    cfg_factor = '0;
   logic [MAX_STAGES*NB_W-1:0] cfg_nbfly = '0;
   logic                       hold = 1'b0;
   logic                       wr_last = 1'b0;
   logic                       sw, busy, done, err;
   logic [2:0]                 stage_idx;

   int checks = 0;
   int errors = 0;
   int beat_cnt = 0;
   int beat_base;

   mrd_rdx2345_if #(.NB_W(NB_W), .ADDR_W(ADDR_W)) rd_if ();

   mrd_stage_seq #(.MAX_STAGES(MAX_STAGES), .NB_W(NB_W), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .cfg_num_stages (cfg_num_stages),
      .cfg_factor     (cfg_factor),
      .cfg_nbfly      (cfg_nbfly),
      .hold           (hold),
      .wr_last        (wr_last),
      .rd             (rd_if.master),
      .sw             (sw),
      .stage_idx      (stage_idx),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_if.rd_valid) beat_cnt <= beat_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_stage(input int i, input int f, input int nb);
      cfg_factor[i*3 +: 3]      = 3'(f);
      cfg_nbfly[i*NB_W +: NB_W] = 12'(nb);
   endtask

   // Leaves the bench sampling in cycle 1 (LOAD).
   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      // ---------------- reset state
      #2;
      chk("rst_valid", 64'(rd_if.rd_valid), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_sw",    64'(sw), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_err",   64'(err), 64'd0);
      #10 rst_n = 1'b1;
      tick();

      // ---------------- single stage f=4 nbfly=3
      cfg_num_stages = 4'd1;
      set_stage(0, 4, 3);
      launch();                                        // c1
      chk("t1_c1_busy",  64'(busy), 64'd1);
      chk("t1_c1_valid", 64'(rd_if.rd_valid), 64'd0);
      tick();                                          // c2
      chk("t1_k0_valid", 64'(rd_if.rd_valid), 64'd1);
      chk("t1_k0_num",   64'(rd_if.rd_twdl_numrtr), 64'd0);
      tick();                                          // c3
      chk("t1_k1_num",   64'(rd_if.rd_twdl_numrtr), 64'd1);
      chk("t1_k1_idx",   64'(rd_if.rd_bank_index), 64'({3'd0, 3'd4, 3'd3, 3'd2, 3'd1}));
      chk("t1_k1_addr",  64'(rd_if.rd_bank_addr), 64'({12'd0, 12'd1, 12'd1, 12'd1, 12'd1}));
      chk("t1_k1_den",   64'(rd_if.rd_twdl_demontr), 64'd12);
      chk("t1_k1_fac",   64'(rd_if.rd_factor), 64'd4);
      tick();                                          // c4
      chk("t1_k2_num",   64'(rd_if.rd_twdl_numrtr), 64'd2);
      tick();                                          // c5
      chk("t1_c5_valid", 64'(rd_if.rd_valid), 64'd0);
      chk("t1_c5_busy",  64'(busy), 64'd1);
      tick();                                          // c6
      wr_last = 1'b1;
      tick();                                          // c7
      wr_last = 1'b0;
      chk("t1_c7_sw",    64'(sw), 64'd1);
      chk("t1_c7_done",  64'(done), 64'd1);
      chk("t1_c7_busy",  64'(busy), 64'd0);
      tick();                                          // c8
      chk("t1_c8_done",  64'(done), 64'd0);
      chk("t1_c8_sw",    64'(sw), 64'd1);

      // ---------------- two stages: (5,7) then (2,1)
      cfg_num_stages = 4'd2;
      set_stage(0, 5, 7);
      set_stage(1, 2, 1);
      beat_base = beat_cnt;
      launch();                                        // c1
      chk("t2_sw_clr",   64'(sw), 64'd0);
      repeat (7) tick();                               // c8: k=6
      chk("t2_k6_num",   64'(rd_if.rd_twdl_numrtr), 64'd6);
      chk("t2_k6_idx",   64'(rd_if.rd_bank_index), 64'({3'd0, 3'd4, 3'd3, 3'd2, 3'd1}));
      chk("t2_k6_den",   64'(rd_if.rd_twdl_demontr), 64'd35);
      tick();                                          // c9
      wr_last = 1'b1;
      tick();                                          // c10
      wr_last = 1'b0;
      chk("t2_sw1",      64'(sw), 64'd1);
      chk("t2_stage1",   64'(stage_idx), 64'd1);
      tick();                                          // c11
      chk("t2_s1_valid", 64'(rd_if.rd_valid), 64'd1);
      chk("t2_s1_idx",   64'(rd_if.rd_bank_index), 64'({3'd0, 3'd0, 3'd0, 3'd1, 3'd0}));
      chk("t2_s1_den",   64'(rd_if.rd_twdl_demontr), 64'd2);
      tick();                                          // c12
      wr_last = 1'b1;
      tick();                                          // c13
      wr_last = 1'b0;
      chk("t2_sw0",      64'(sw), 64'd0);
      chk("t2_done",     64'(done), 64'd1);
      chk("t2_beats",    64'(beat_cnt - beat_base), 64'd8);
      tick();

      // ---------------- hold for 3 cycles after k=1, f=3 nbfly=4
      cfg_num_stages = 4'd1;
      set_stage(0, 3, 4);
      beat_base = beat_cnt;
      launch();                                        // c1
      tick();                                          // c2
      tick();                                          // c3: k=1
      chk("t3_k1_num",   64'(rd_if.rd_twdl_numrtr), 64'd1);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin                // c4..c6
         tick();
         chk("t3_hold_valid", 64'(rd_if.rd_valid), 64'd0);
         chk("t3_hold_num",   64'(rd_if.rd_twdl_numrtr), 64'd1);
      end
      hold = 1'b0;
      tick();                                          // c7: k=2
      chk("t3_k2_valid", 64'(rd_if.rd_valid), 64'd1);
      chk("t3_k2_num",   64'(rd_if.rd_twdl_numrtr), 64'd2);
      chk("t3_k2_idx",   64'(rd_if.rd_bank_index), 64'({3'd0, 3'd0, 3'd4, 3'd3, 3'd2}));
      chk("t3_k2_addr",  64'(rd_if.rd_bank_addr), 64'({12'd0, 12'd0, 12'd2, 12'd2, 12'd2}));
      tick();                                          // c8: k=3
      chk("t3_k3_num",   64'(rd_if.rd_twdl_numrtr), 64'd3);
      tick();                                          // c9
      chk("t3_beats",    64'(beat_cnt - beat_base), 64'd4);
      wr_last = 1'b1;
      tick();
      wr_last = 1'b0;
      chk("t3_done",     64'(done), 64'd1);
      tick();

      // ---------------- ignored start / wr_last during RUN, f=2 nbfly=3
      set_stage(0, 2, 3);
      launch();                                        // c1
      chk("t4_sw_clr",   64'(sw), 64'd0);
      tick();                                          // c2
      start   = 1'b1;
      wr_last = 1'b1;
      tick();                                          // c3 (final RUN beat issued here)
      start   = 1'b0;
      chk("t4_k1_num",   64'(rd_if.rd_twdl_numrtr), 64'd1);
      tick();                                          // c4
      wr_last = 1'b0;
      chk("t4_k2_num",   64'(rd_if.rd_twdl_numrtr), 64'd2);
      tick();
      tick();                                          // c6
      chk("t4_wait_busy", 64'(busy), 64'd1);
      chk("t4_wait_sw",   64'(sw), 64'd0);
      chk("t4_wait_done", 64'(done), 64'd0);
      wr_last = 1'b1;
      tick();
      wr_last = 1'b0;
      chk("t4_done",     64'(done), 64'd1);
      chk("t4_sw",       64'(sw), 64'd1);
      tick();
      chk("t4_idle",     64'(busy), 64'd0);

      // ---------------- skipped empty stage
      cfg_num_stages = 4'd2;
      set_stage(0, 3, 0);
      set_stage(1, 2, 1);
      launch();                                        // c1: LOAD stage 0
      tick();                                          // c2: LOAD stage 1
      chk("t5_skip_stage", 64'(stage_idx), 64'd1);
      chk("t5_skip_sw",    64'(sw), 64'd0);
      tick();                                          // c3
      chk("t5_skip_valid", 64'(rd_if.rd_valid), 64'd1);
      chk("t5_skip_fac",   64'(rd_if.rd_factor), 64'd2);
      wr_last = 1'b1;
      tick();
      wr_last = 1'b0;
      chk("t5_skip_done",  64'(done), 64'd1);
      tick();

      // ---------------- illegal factor
      cfg_num_stages = 4'd1;
      set_stage(0, 6, 2);
      beat_base = beat_cnt;
      launch();                                        // c1
      chk("t6_c1_busy",  64'(busy), 64'd1);
      tick();                                          // c2
      chk("t6_done",     64'(done), 64'd1);
      chk("t6_err",      64'(err), 64'd1);
      chk("t6_busy",     64'(busy), 64'd0);
      chk("t6_beats",    64'(beat_cnt - beat_base), 64'd0);
      tick();                                          // IDLE
      set_stage(0, 2, 1);
      launch();
      chk("t6_err_clr",  64'(err), 64'd0);
      tick();
      wr_last = 1'b1;
      tick();
      wr_last = 1'b0;
      chk("t6_re_done",  64'(done), 64'd1);
      tick();

      // ---------------- reset mid-run
      set_stage(0, 4, 5);
      launch();
      tick();
      tick();
      tick();                                          // c4: k=2
      chk("t7_k2_num",   64'(rd_if.rd_twdl_numrtr), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("t7_rst_valid", 64'(rd_if.rd_valid), 64'd0);
      chk("t7_rst_busy",  64'(busy), 64'd0);
      chk("t7_rst_num",   64'(rd_if.rd_twdl_numrtr), 64'd0);
      chk("t7_rst_idx",   64'(rd_if.rd_bank_index), 64'd0);
      #10 rst_n = 1'b1;
      tick();
      launch();
      tick();                                          // c2
      chk("t7_re_valid", 64'(rd_if.rd_valid), 64'd1);
      chk("t7_re_num",   64'(rd_if.rd_twdl_numrtr), 64'd0);
      chk("t7_re_stage", 64'(stage_idx), 64'd0);
      chk("t7_re_idx",   64'(rd_if.rd_bank_index), 64'({3'd0, 3'd3, 3'd2, 3'd1, 3'd0}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mrd_stage_seq.md
# mrd_stage_seq

Read-side stage sequencer for the mixed-radix (2/3/4/5) DFT engine. It walks a programmed list of stages, and for each stage issues one butterfly read beat per cycle: per-lane bank index and address, radix factor and twiddle numerator/denominator. It drives the ping-pong `sw` select of the memory/butterfly switch, flipping it once the write path reports the last write of a stage. It sits upstream of the switch and is the initiator of the `mrd_rdx2345_if` read stream that the switch forwards into the butterfly.

## Interface
- `MAX_STAGES`, default 8: depth of the stage configuration table.
- `NB_W`, default 12: width of the per-stage butterfly count.
- `ADDR_W`, default 12: bank address width.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse that launches a transform. Ignored while `busy`.
- `cfg_num_stages`  in  4  stage count, 1..`MAX_STAGES`. Sampled at `start`.
- `cfg_factor`  in  `MAX_STAGES`×3  radix per stage. Legal values are 2..5.
- `cfg_nbfly`  in  `MAX_STAGES`×`NB_W`  butterflies per stage.
- `hold`  in  1  stall. While high, no beat is issued and all counters freeze.
- `wr_last`  in  1  pulse from the write path: last write of the current stage has committed.
- `rd_valid`  out  1  beat valid.
- `rd_factor`  out  3  radix of the current beat.
- `rd_bank_index`  out  5×3  bank index for each lane.
- `rd_bank_addr`  out  5×`ADDR_W`  bank address for each lane.
- `rd_twdl_numrtr`  out  `NB_W`  twiddle numerator, equal to the butterfly index k.
- `rd_twdl_demontr`  out  `NB_W`+3  twiddle denominator, equal to factor×nbfly.
- `sw`  out  1  ping-pong select for the switch.
- `stage_idx`  out  3  current stage.
- `busy`  out  1  high from LOAD until DONE.
- `done`  out  1  single-cycle pulse at transform end.
- `err`  out  1  sticky. Cleared by the next accepted `start`.

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE → LOAD on `start`.
  - Latches the whole configuration table.
  - Clears `sw`, `stage_idx` and `err`.
- LOAD takes one cycle.
  - Registers factor f and nbfly for `stage_idx`.
  - Computes demontr = f×nbfly.
  - Clears the butterfly counter k and the mod-5 skew counter s.
  - If f is not in 2..5: sets `err` and goes to DONE.
  - If nbfly = 0: the stage is skipped and `sw` does not toggle. The FSM goes to LOAD of the next stage, or to DONE if it was the last stage.
  - Otherwise goes to RUN.
- RUN issues one beat per cycle while `hold` = 0.
  - Lane i < f: `rd_bank_index[i]` = (i+s) mod 5 and `rd_bank_addr[i]` = k.
  - Lane i ≥ f: bank index and address are 0.
  - `rd_twdl_numrtr` = k.
  - k increments by 1. s increments mod 5 (wraps 4→0).
  - After the beat with k = nbfly−1, goes to DRAIN.
- DRAIN waits for `wr_last`.
  - On `wr_last`, `sw` toggles.
  - If `stage_idx` = `cfg_num_stages`−1: goes to DONE.
  - Otherwise increments `stage_idx` and goes to LOAD.
- DONE takes one cycle: pulses `done`, then goes to IDLE. `sw` keeps its final value until the next `start`.
- `wr_last` outside DRAIN is ignored.
- `wr_last` coincident with the final RUN beat is ignored, because the stage is not drained yet.
- Asserting `rst_n` mid-operation returns the block to IDLE immediately. Any in-flight stage is abandoned.

## Timing
- Reset values: all outputs 0 and FSM in IDLE.
- All outputs are registered.
- Launch latency: `start` is sampled at cycle 0, LOAD runs at cycle 1, and the first `rd_valid` appears at cycle 2.
- Throughput: with `hold` low, one beat per cycle. A stage occupies nbfly consecutive cycles.
- `hold` takes effect on the next cycle's output.
  - While `hold` is high, `rd_valid` = 0 and the other `rd_*` outputs hold their last values.
  - Counters resume from the held k and s.
- `wr_last` sampled in DRAIN at cycle t:
  - `sw` flips at t+1.
  - Next-stage LOAD runs at t+1.
  - Next-stage first beat appears at t+2.
- `done` is high for exactly one cycle. `busy` falls in the same cycle `done` rises.

## Structure
- Shared package `mrd_pkg` holds:
  - `NBANK` = 5 and `MAX_RADIX` = 5.
  - `mrd_factor_t` (3-bit).
  - The FSM state enum `mrd_seq_state_t`.
  - Shared by the write-side sequencer.
- One sub-module, `mrd_mod5_cnt`: a 3-bit wrap-at-4 counter with clear and enable. It provides s and a lane-offset adder, giving (i+s) mod 5 without a divider.

## Test plan
- **Single stage:** `start` with 1 stage, f = 4, nbfly = 3.
  - Beats k = 0,1,2 at cycles 2..4.
  - At k = 1: lane indices are 1,2,3,4 and lane 4 is 0. Address is 1. demontr = 12.
  - `wr_last` at cycle 6 → `sw` = 1 at cycle 7, `done` pulses.
- **Two stages:** stage 0 is f = 5, nbfly = 7; stage 1 is f = 2, nbfly = 1.
  - At k = 6: lane indices are 1,2,3,4,0 (mod-5 wrap).
  - `sw` goes 0→1→0 across the two stages. `stage_idx` goes 0→1. Exactly 8 beats in total.
- **Hold:** assert `hold` for 3 cycles after beat k = 1 (f = 3, nbfly = 4).
  - `rd_valid` is low for 3 cycles.
  - The next beat is k = 2 with unchanged outputs.
  - 4 beats in total.
- **Ignored events:** a `start` pulse during RUN is ignored, and a `wr_last` during RUN is ignored.
  - The stage still waits in DRAIN for a later `wr_last`.
- **Illegal factor:** f = 6 in stage 0.
  - No `rd_valid`, `err` = 1, `done` pulses at cycle 2.
  - The next `start` clears `err`.
- **Reset mid-run:** `rst_n` low during RUN at k = 2.
  - All outputs go to 0 and `busy` = 0 asynchronously.
  - After release, a fresh `start` restarts from stage 0 with k = 0.
